stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 one_hz  input  1  one-cycle tick enable, nominally 1 Hz.
REQ-004 two_hz  input  1  one-cycle tick enable, nominally 2 Hz; used as the adjust-rate tick.
REQ-005 blink  input  1  level; high = "on" phase of the adjust blink.
REQ-006 fast  input  1  one-cycle tick enable, nominally 500 Hz; used as the display-scan tick.
REQ-007 pause_btn  input  1  raw, asynchronous pause button, active-high.
REQ-008 adj  input  1  level; 1 = adjust mode, 0 = run mode.
REQ-009 sel  input  1  level; in adjust mode, 0 = minutes field, 1 = seconds field.
REQ-010 seg  output  7  cathodes, active-low; seg[0]=a ... seg[6]=g.
REQ-011 an  output  4  digit anodes, active-low, one-hot; an[0] = rightmost digit.

Function
REQ-012 Time state SHALL be four BCD digits:
  - min_tens 0-5, min_ones 0-9, sec_tens 0-5, sec_ones 0-9.
  - No digit ever holds an illegal value.
REQ-013 pause_btn SHALL pass through a 2-flop synchronizer plus one edge-detect flop.
REQ-014 Each synchronized rising edge SHALL toggle the paused flag exactly once, however long the button is held.
REQ-015 Run-mode counting (adj=0):
  - Trigger: one_hz=1 and the paused flag's registered value, as held before this edge, is 0.
  - Effect: time increments by one second on that edge.
REQ-016 Carry rules:
  - sec 59 -> 00 carries one minute.
  - Full wrap 59:59 -> 00:00 with no flag.
REQ-017 Adjust mode (adj=1):
  - one_hz and the paused flag SHALL be ignored.
  - A pause edge still toggles the paused flag.
REQ-018 Adjust increment on two_hz=1:
  - sel=0: minutes +1, wrapping 59 -> 00.
  - sel=1: seconds +1, wrapping 59 -> 00, with no carry into minutes.
REQ-019 On leaving adjust (adj 1->0), counting SHALL resume from the adjusted value on the next qualifying one_hz.
REQ-020 A 2-bit scan index SHALL advance 0->1->2->3->0 on each fast=1 cycle and hold otherwise.
REQ-021 Scan index to digit mapping:
  - 0: an=1110, shows sec_ones.
  - 1: an=1101, shows sec_tens.
  - 2: an=1011, shows min_ones.
  - 3: an=0111, shows min_tens.
REQ-022 seg SHALL carry the standard active-low 7-segment code of the selected digit, e.g.:
  - 0 = 1000000
  - 1 = 1111001
  - 5 = 0010010
  - 9 = 0010000
REQ-023 Blanking: when adj=1, blink=0 and the scanned digit belongs to the field chosen by sel, seg SHALL be 1111111 while an is still driven normally.
REQ-024 seg and an SHALL be registered, reflecting the scan index and time state of the previous cycle (one-cycle latency).
REQ-025 Simultaneous events:
  - one_hz with a pause edge: counting uses the pre-toggle paused value.
  - two_hz with a change of sel: counting uses the sel value sampled that cycle.
  - one_hz and two_hz together in adjust: only the adjust increment applies.
REQ-026 No input combination SHALL produce more than one increment per clock.

Reset
REQ-027 While rst=1, the block SHALL hold:
  - time 00:00
  - paused=0
  - synchronizer and edge-detect flops 0
  - scan index 0
  - an=1111, seg=1111111
REQ-028 Reset asserted mid-count or mid-adjust SHALL clear state immediately, with no clock required.
REQ-029 On the first clock after release, the block SHALL drive an=1110 and seg=1000000.

Verification
REQ-030 Bench SHALL cover at least these directed scenarios:
  - Reset, then 60 one_hz pulses with adj=0 -> time 01:00; a further 3539 pulses -> 59:59; one more -> 00:00.
  - Pulse pause_btn for 20 cycles, then apply 5 one_hz pulses -> time unchanged. Pulse again, apply 5 -> time +5 s. Verify exactly one toggle per press.
  - adj=1, sel=1 at 00:58, 3 two_hz pulses -> 00:01 with minutes still 00. Then sel=0 at 59:xx, 1 pulse -> 00:xx. one_hz pulses ignored throughout.
  - Time 12:34, adj=0, 4 fast pulses -> an sequence 1110/1101/1011/0111, seg codes 4, 3, 2, 1 each one cycle after the index changes. Then adj=1, sel=0, blink=0 -> seg=1111111 on an=1011 and 0111; sec digits still shown.
  - Assert rst asynchronously between clock edges mid-count at 07:42 -> outputs go to an=1111, seg=1111111 before the next edge. After release, the display shows 0 on an=1110.
  - one_hz and a pause edge in the same cycle while running -> time increments once and is paused afterward.

Source files
------------

// File: rtl/stopwatch_if.sv
// stopwatch_if: tick, control and display signals shared by the stopwatch core and its driver.
interface stopwatch_if;
    logic       one_hz;
    logic       two_hz;
    logic       blink;
    logic       fast;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;
    modport master (output one_hz, two_hz, blink, fast, pause_btn, adj, sel, input seg, an);
    modport slave (input one_hz, two_hz, blink, fast, pause_btn, adj, sel, output seg, an);
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch with synchronized pause toggle, per-field adjust
// and a registered four-digit multiplexed 7-segment scan.
module stopwatch_core (
    input logic        clk,
    input logic        rst,
    stopwatch_if.slave bus
);
    logic [2:0] mt_q, mt_d, st_q, st_d;
    logic [3:0] mo_q, mo_d, so_q, so_d;
    logic       sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d, paused_q, paused_d;
    logic [1:0] scan_q, scan_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       run_inc, adj_min, adj_sec, sec_wrap, blank;
    logic [3:0] digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        sync1_d  = bus.pause_btn;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        paused_d = paused_q ^ (sync2_q & ~edge_q);
        // adjust mode owns the increment, so one_hz and pause are ignored there
        run_inc  = !bus.adj && bus.one_hz && !paused_q;
        adj_min  = bus.adj && bus.two_hz && !bus.sel;
        adj_sec  = bus.adj && bus.two_hz && bus.sel;
        sec_wrap = st_q == 3'd5 && so_q == 4'd9;
        so_d = so_q;
        st_d = st_q;
        mo_d = mo_q;
        mt_d = mt_q;
        if (run_inc || adj_sec) begin
            so_d = so_q == 4'd9 ? 4'd0 : so_q + 4'd1;
            st_d = so_q != 4'd9 ? st_q : sec_wrap ? 3'd0 : st_q + 3'd1;
        end
        if ((run_inc && sec_wrap) || adj_min) begin
            mo_d = mo_q == 4'd9 ? 4'd0 : mo_q + 4'd1;
            mt_d = mo_q != 4'd9 ? mt_q : mt_q == 3'd5 ? 3'd0 : mt_q + 3'd1;
        end
        scan_d = scan_q + {1'b0, bus.fast};
        digit  = scan_q == 2'd0 ? so_q : scan_q == 2'd1 ? {1'b0, st_q} :
                 scan_q == 2'd2 ? mo_q : {1'b0, mt_q};
        // scan[1] set means a minutes digit; blank the field chosen by sel
        blank  = bus.adj && !bus.blink && (scan_q[1] ^ bus.sel);
        an_d   = ~(4'b0001 << scan_q);
        seg_d  = blank ? 7'b1111111 : seg_code(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mt_q     <= '0;
            mo_q     <= '0;
            st_q     <= '0;
            so_q     <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            paused_q <= 1'b0;
            scan_q   <= '0;
            seg_q    <= 7'b1111111;
            an_q     <= 4'b1111;
        end else begin
            mt_q     <= mt_d;
            mo_q     <= mo_d;
            st_q     <= st_d;
            so_q     <= so_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            paused_q <= paused_d;
            scan_q   <= scan_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scenarios plus random stimulus against a seconds-count reference model.
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    stopwatch_if sw();
    stopwatch_core dut (.clk(clk), .rst(rst), .bus(sw));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int         m_t, m_scan, mm, ss, d;
    bit         m_paused, tog, blank;
    logic [2:0] hist;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: time kept as total seconds; display derived from it by division.
    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_scan = 0; m_paused = 0; hist = 3'b000;
            exp_an = 4'b1111; exp_seg = 7'b1111111;
        end else begin
            mm = m_t / 60;
            ss = m_t % 60;
            d = m_scan == 0 ? ss % 10 : m_scan == 1 ? ss / 10 : m_scan == 2 ? mm % 10 : mm / 10;
            blank = sw.adj && !sw.blink && ((m_scan >= 2) == !sw.sel);
            exp_an = an_tab[m_scan];
            exp_seg = blank ? 7'b1111111 : seg_tab[d];
            tog = hist[1] && !hist[2];
            if (sw.adj) begin
                if (sw.two_hz && sw.sel) m_t = mm * 60 + (ss + 1) % 60;
                else if (sw.two_hz) m_t = ((mm + 1) % 60) * 60 + ss;
            end else if (sw.one_hz && !m_paused) m_t = (m_t + 1) % 3600;
            if (tog) m_paused = !m_paused;
            hist = {hist[1:0], sw.pause_btn};
            m_scan = (m_scan + (sw.fast ? 1 : 0)) % 4;
        end
        #1;
        chk("an", {28'd0, sw.an}, {28'd0, exp_an});
        chk("seg", {25'd0, sw.seg}, {25'd0, exp_seg});
    end

    task automatic pulse(input int n, input logic o, input logic t);
        for (int i = 0; i < n; i++) begin
            sw.one_hz = o; sw.two_hz = t;
            @(negedge clk);
            sw.one_hz = 0; sw.two_hz = 0;
            @(negedge clk);
        end
    endtask

    task automatic show_time(input logic [15:0] exp, input string name);
        logic [3:0] dg [4];
        for (int j = 0; j < 4; j++) dg[j] = 4'hf;
        sw.one_hz = 0; sw.two_hz = 0; sw.blink = 1; sw.fast = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 3) sw.fast = 0;
            for (int j = 0; j < 4; j++)
                if (sw.an == an_tab[j])
                    for (int k = 0; k < 10; k++)
                        if (sw.seg == seg_tab[k]) dg[j] = 4'(k);
        end
        @(negedge clk);
        chk(name, {16'd0, dg[3], dg[2], dg[1], dg[0]}, {16'd0, exp});
    endtask

    task automatic press(input int n);
        sw.pause_btn = 1;
        repeat (n) @(negedge clk);
        sw.pause_btn = 0;
        repeat (4) @(negedge clk);
    endtask

    logic [6:0] lit_run [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [6:0] lit_blk [4] = '{7'b0011001, 7'b0110000, 7'b1111111, 7'b1111111};

    initial begin
        sw.one_hz = 0; sw.two_hz = 0; sw.blink = 1; sw.fast = 0;
        sw.pause_btn = 0; sw.adj = 0; sw.sel = 0;
        repeat (2) @(negedge clk);
        chk("reset_an", {28'd0, sw.an}, 32'hf);
        chk("reset_seg", {25'd0, sw.seg}, 32'h7f);
        rst = 0;
        @(posedge clk); #1;
        chk("first_an", {28'd0, sw.an}, 32'he);
        chk("first_seg", {25'd0, sw.seg}, 32'h40);
        @(negedge clk);

        pulse(60, 1, 0);   show_time(16'h0100, "t_0100");
        pulse(3539, 1, 0); show_time(16'h5959, "t_5959");
        pulse(1, 1, 0);    show_time(16'h0000, "t_wrap");

        press(20); pulse(5, 1, 0); show_time(16'h0000, "paused_hold");
        press(20); pulse(5, 1, 0); show_time(16'h0005, "resumed");

        pulse(53, 1, 0); show_time(16'h0058, "t_0058");
        sw.adj = 1; sw.sel = 1;
        pulse(3, 1, 1); show_time(16'h0001, "adj_sec_wrap");
        pulse(4, 1, 0); show_time(16'h0001, "adj_ignore_1hz");
        sw.sel = 0;
        pulse(59, 0, 1); show_time(16'h5901, "adj_min_59");
        pulse(1, 0, 1);  show_time(16'h0001, "adj_min_wrap");
        sw.adj = 0;
        pulse(1, 1, 0);  show_time(16'h0002, "resume_after_adj");

        sw.adj = 1; sw.sel = 0; pulse(12, 0, 1);
        sw.sel = 1; pulse(32, 0, 1);
        sw.adj = 0; show_time(16'h1234, "t_1234");
        sw.fast = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) sw.fast = 0;
            chk("scan_an", {28'd0, sw.an}, {28'd0, an_tab[i]});
            chk("scan_seg", {25'd0, sw.seg}, {25'd0, lit_run[i]});
        end
        @(negedge clk);
        sw.adj = 1; sw.sel = 0; sw.blink = 0; sw.fast = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) sw.fast = 0;
            chk("blank_an", {28'd0, sw.an}, {28'd0, an_tab[i]});
            chk("blank_seg", {25'd0, sw.seg}, {25'd0, lit_blk[i]});
        end
        @(negedge clk);
        sw.blink = 1; sw.adj = 0;

        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        sw.adj = 1; sw.sel = 0; pulse(7, 0, 1);
        sw.sel = 1; pulse(42, 0, 1);
        sw.adj = 0; show_time(16'h0742, "t_0742");
        sw.one_hz = 1;
        #2 rst = 1;
        #1;
        chk("async_rst_an", {28'd0, sw.an}, 32'hf);
        chk("async_rst_seg", {25'd0, sw.seg}, 32'h7f);
        @(negedge clk);
        rst = 0; sw.one_hz = 0;
        @(posedge clk); #1;
        chk("post_rst_an", {28'd0, sw.an}, 32'he);
        chk("post_rst_seg", {25'd0, sw.seg}, 32'h40);
        @(negedge clk);
        show_time(16'h0000, "post_rst_time");

        sw.pause_btn = 1;
        repeat (2) @(negedge clk);
        sw.one_hz = 1;
        @(negedge clk);
        sw.one_hz = 0;
        repeat (3) @(negedge clk);
        sw.pause_btn = 0;
        repeat (4) @(negedge clk);
        pulse(3, 1, 0); show_time(16'h0001, "simul_pause");
        press(3); pulse(2, 1, 0); show_time(16'h0003, "simul_resume");

        for (int i = 0; i < 3000; i++) begin
            sw.one_hz = $urandom_range(0, 2) == 0;
            sw.two_hz = $urandom_range(0, 2) == 0;
            sw.fast = $urandom_range(0, 1) == 1;
            sw.blink = $urandom_range(0, 1) == 1;
            sw.sel = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) sw.adj = !sw.adj;
            if ($urandom_range(0, 9) == 0) sw.pause_btn = !sw.pause_btn;
            @(negedge clk);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
